// File: rtl/axi_st_d64_nordy_pkg.sv
// Shared widths, field offsets and FSM encoding for the 64-bit no-ready AXI-ST TX scheduler.
// Link words are {tvalid, tlast, tdata, tkeep}, least significant field last.
package axi_st_d64_nordy_pkg;

   localparam int TKEEP_W    = 8;
   localparam int TDATA_W    = 64;
   localparam int ST_W       = 74;

   localparam int TKEEP_LSB  = 0;
   localparam int TDATA_LSB  = 8;
   localparam int TLAST_BIT  = 72;
   localparam int TVALID_BIT = 73;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      PKT   = 2'd2
   } tx_state_e;

   function automatic logic [ST_W-1:0] pack_beat(input logic               tlast,
                                                 input logic [TDATA_W-1:0] tdata,
                                                 input logic [TKEEP_W-1:0] tkeep);
      logic [ST_W-1:0] w;
      w                          = '0;
      w[TVALID_BIT]              = 1'b1;
      w[TLAST_BIT]               = tlast;
      w[TDATA_LSB +: TDATA_W]    = tdata;
      w[TKEEP_LSB +: TKEEP_W]    = tkeep;
      return w;
   endfunction

endpackage

// File: rtl/axi_st_d64_nordy_rr_arb.sv
// Combinational rotate-priority pick: the first asserted request at or above ptr,
// wrapping modulo NUM_REQ, wins.
module axi_st_d64_nordy_rr_arb #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [ID_W-1:0]    winner,
   output logic               any
);

   logic [ID_W:0]   sum;
   logic [ID_W-1:0] idx;

   // Scan from the farthest offset down so the nearest request above ptr is the last writer.
   always_comb begin
      // NOTE: every variable gets a default before the loop, so no path can infer a latch.
      winner = '0;
      sum    = '0;
      idx    = '0;
      any    = |req;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         sum = {1'b0, ptr} + (ID_W + 1)'(i);
         if (sum >= (ID_W + 1)'(NUM_REQ)) begin
            sum = sum - (ID_W + 1)'(NUM_REQ);
         end
         idx = sum[ID_W-1:0];
         if (req[idx]) begin
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/axi_st_d64_nordy_tx_sched.sv
// Packet-granular scheduler sharing one no-backpressure 64-bit AXI-ST link between
// NUM_REQ requesters, with Gen1/Gen2 beat pacing and a sticky oversize flag.
module axi_st_d64_nordy_tx_sched
   import axi_st_d64_nordy_pkg::*;
#(
   parameter  int NUM_REQ   = 4,
   parameter  int MAX_BEATS = 256,
   localparam int ID_W      = $clog2(NUM_REQ),
   localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
   input  logic                   clk_wr,
   input  logic                   rst_wr,
   input  logic [NUM_REQ*8-1:0]   req_tkeep,
   input  logic [NUM_REQ*64-1:0]  req_tdata,
   input  logic [NUM_REQ-1:0]     req_tlast,
   input  logic [NUM_REQ-1:0]     req_tvalid,
   output logic [NUM_REQ-1:0]     req_tready,
   input  logic                   link_enable,
   input  logic                   m_gen2_mode,
   output logic [ST_W-1:0]        txfifo_st_data,
   output logic [ID_W-1:0]        grant_id,
   output logic                   pkt_active,
   output logic                   err_oversize
);

   tx_state_e          state, state_next;
   logic [ID_W-1:0]    rr_ptr, winner, next_ptr;
   logic [CNT_W-1:0]   beat_cnt;
   logic               any_req, phase, slot, accept, grant_now;
   logic [TDATA_W-1:0] cur_tdata;
   logic [TKEEP_W-1:0] cur_tkeep;
   logic               cur_tlast;

   axi_st_d64_nordy_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
      .req    (req_tvalid),
      .ptr    (rr_ptr),
      .winner (winner),
      .any    (any_req)
   );

   assign slot      = m_gen2_mode | ~phase;
   assign cur_tdata = req_tdata[grant_id*TDATA_W +: TDATA_W];
   assign cur_tkeep = req_tkeep[grant_id*TKEEP_W +: TKEEP_W];
   assign cur_tlast = req_tlast[grant_id];
   assign accept    = (state != IDLE) & slot & req_tvalid[grant_id];
   assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

   always_comb begin
      state_next = state;
      grant_now  = 1'b0;
      req_tready = '0;
      if (state != IDLE) begin
         req_tready[grant_id] = slot;
      end
      unique case (state)
         IDLE: begin
            if (link_enable && any_req) begin
               state_next = GRANT;
               grant_now  = 1'b1;
            end
         end
         GRANT, PKT: begin
            if (accept) begin
               state_next = cur_tlast ? IDLE : PKT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_wr) begin
      if (rst_wr) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk_wr) begin
      // NOTE: non-blocking throughout, so every register here samples pre-edge values.
      if (rst_wr) begin
         txfifo_st_data <= '0;
         grant_id       <= '0;
         pkt_active     <= 1'b0;
         err_oversize   <= 1'b0;
         rr_ptr         <= '0;
         phase          <= 1'b0;
         beat_cnt       <= '0;
      end else begin
         phase          <= m_gen2_mode ? 1'b0 : ~phase;
         txfifo_st_data <= accept ? pack_beat(cur_tlast, cur_tdata, cur_tkeep) : '0;
         if (grant_now) begin
            grant_id   <= winner;
            pkt_active <= 1'b1;
         end
         if (accept) begin
            if (cur_tlast) begin
               beat_cnt   <= '0;
               pkt_active <= 1'b0;
               rr_ptr     <= next_ptr;
            end else if (beat_cnt != CNT_W'(MAX_BEATS)) begin
               beat_cnt <= beat_cnt + 1'b1;
               // Oversize is flagged but the packet keeps flowing untouched.
               if (beat_cnt == CNT_W'(MAX_BEATS - 1)) begin
                  err_oversize <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_st_d64_nordy_tx_sched.sv
// Self-checking bench: per-requester packet queues drive the DUT, a cycle-level
// reference model predicts every output, and directed scenarios check the timing rules.
`timescale 1ns/1ps
module tb_axi_st_d64_nordy_tx_sched;

   localparam int NUM_REQ   = 4;
   localparam int MAX_BEATS = 4;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   typedef struct {
      int          cyc;
      logic [73:0] w;
   } cap_t;

   logic                  clk_wr = 1'b0;
   logic                  rst_wr;
   logic [NUM_REQ*8-1:0]  req_tkeep;
   logic [NUM_REQ*64-1:0] req_tdata;
   logic [NUM_REQ-1:0]    req_tlast;
   logic [NUM_REQ-1:0]    req_tvalid;
   logic [NUM_REQ-1:0]    req_tready;
   logic                  link_enable;
   logic                  m_gen2_mode;
   logic [73:0]           txfifo_st_data;
   logic [1:0]            grant_id;
   logic                  pkt_active;
   logic                  err_oversize;

   always #5 clk_wr = ~clk_wr;

   axi_st_d64_nordy_tx_sched #(.NUM_REQ(NUM_REQ), .MAX_BEATS(MAX_BEATS)) dut (
      .clk_wr         (clk_wr),
      .rst_wr         (rst_wr),
      .req_tkeep      (req_tkeep),
      .req_tdata      (req_tdata),
      .req_tlast      (req_tlast),
      .req_tvalid     (req_tvalid),
      .req_tready     (req_tready),
      .link_enable    (link_enable),
      .m_gen2_mode    (m_gen2_mode),
      .txfifo_st_data (txfifo_st_data),
      .grant_id       (grant_id),
      .pkt_active     (pkt_active),
      .err_oversize   (err_oversize)
   );

   int    tests_run    = 0;
   int    tests_failed = 0;
   int    cyc          = 0;
   beat_t pq[NUM_REQ][$];
   bit    hold[NUM_REQ];
   cap_t  cap[$];

   // Reference model state: what the link should look like, derived from the packet rules.
   bit          ref_busy  = 0;
   int          ref_gid   = 0;
   int          ref_ptr   = 0;
   int          ref_cnt   = 0;
   bit          ref_phase = 0;
   bit          ref_err   = 0;
   logic [73:0] ref_word  = '0;

   task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit offers(input int i);
      return !hold[i] && pq[i].size() > 0;
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < NUM_REQ; i++) if (pq[i].size() > 0) return 0;
      return 1;
   endfunction

   function automatic void drive();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (offers(i)) begin
            req_tvalid[i]         = 1'b1;
            req_tdata[i*64 +: 64] = pq[i][0].data;
            req_tkeep[i*8 +: 8]   = pq[i][0].keep;
            req_tlast[i]          = pq[i][0].last;
         end else begin
            req_tvalid[i]         = 1'b0;
            req_tdata[i*64 +: 64] = '0;
            req_tkeep[i*8 +: 8]   = '0;
            req_tlast[i]          = 1'b0;
         end
      end
   endfunction

   function automatic void push_beat(input int id, input logic [63:0] d, input logic [7:0] k, input logic l);
      beat_t b;
      b.data = d;
      b.keep = k;
      b.last = l;
      pq[id].push_back(b);
   endfunction

   function automatic void push_pkt(input int id, input int len);
      for (int b = 0; b < len; b++) push_beat(id, {$urandom, $urandom}, 8'($urandom), b == len - 1);
   endfunction

   // One clock: drive, check predicted outputs at the falling edge, advance the model.
   task automatic step();
      logic [NUM_REQ-1:0] exp_rdy;
      bit    slot, acc, found;
      int    idx;
      beat_t b;
      drive();
      @(negedge clk_wr);
      slot    = m_gen2_mode || !ref_phase;
      exp_rdy = '0;
      if (ref_busy && slot) exp_rdy[ref_gid] = 1'b1;
      chk("req_tready",     74'(req_tready),   74'(exp_rdy));
      chk("grant_id",       74'(grant_id),     74'(ref_gid));
      chk("pkt_active",     74'(pkt_active),   74'(ref_busy));
      chk("err_oversize",   74'(err_oversize), 74'(ref_err));
      chk("txfifo_st_data", txfifo_st_data,    ref_word);
      if (txfifo_st_data[73] === 1'b1) cap.push_back('{cyc, txfifo_st_data});
      acc = ref_busy && slot && offers(ref_gid);
      b   = '{default: '0};
      if (acc) b = pq[ref_gid].pop_front();
      if (rst_wr) begin
         ref_busy = 0; ref_gid = 0; ref_ptr = 0; ref_cnt = 0;
         ref_phase = 0; ref_err = 0; ref_word = '0;
      end else begin
         ref_word = acc ? {1'b1, b.last, b.data, b.keep} : 74'd0;
         if (!ref_busy) begin
            found = 0;
            if (link_enable) begin
               for (int k = 0; k < NUM_REQ; k++) begin
                  idx = (ref_ptr + k) % NUM_REQ;
                  if (!found && offers(idx)) begin
                     found    = 1;
                     ref_gid  = idx;
                     ref_busy = 1;
                  end
               end
            end
         end else if (acc) begin
            if (b.last) begin
               ref_busy = 0;
               ref_ptr  = (ref_gid + 1) % NUM_REQ;
               ref_cnt  = 0;
            end else begin
               if (ref_cnt < MAX_BEATS) ref_cnt++;
               if (ref_cnt == MAX_BEATS) ref_err = 1;
            end
         end
         ref_phase = m_gen2_mode ? 1'b0 : !ref_phase;
      end
      @(posedge clk_wr);
      #1;
      cyc++;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (n < budget && !(all_empty() && !ref_busy && ref_word == '0)) begin
         step();
         n++;
      end
      chk("drain_done", 74'(all_empty() && !ref_busy), 74'd1);
   endtask

   task automatic do_reset();
      rst_wr = 1'b1;
      step();
      rst_wr = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int order[5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < NUM_REQ; i++) hold[i] = 0;
      rst_wr      = 1'b1;
      link_enable = 1'b1;
      m_gen2_mode = 1'b1;
      drive();
      repeat (2) @(posedge clk_wr);
      #1;
      rst_wr = 1'b0;
      chk("reset_txfifo",  txfifo_st_data, 74'd0);
      chk("reset_outputs", 74'({req_tready, grant_id, pkt_active, err_oversize}), 74'd0);

      // Single 3-beat packet from requester 2 in Gen2.
      cap.delete();
      push_beat(2, 64'h11, 8'hFF, 1'b0);
      push_beat(2, 64'h22, 8'hFF, 1'b0);
      push_beat(2, 64'h33, 8'hFF, 1'b1);
      drain(50);
      chk("t1_count", 74'(cap.size()), 74'd3);
      if (cap.size() == 3) begin
         chk("t1_w0", cap[0].w, {2'b10, 64'h11, 8'hFF});
         chk("t1_w1", cap[1].w, {2'b10, 64'h22, 8'hFF});
         chk("t1_w2", cap[2].w, {2'b11, 64'h33, 8'hFF});
         chk("t1_back_to_back", 74'(cap[2].cyc - cap[0].cyc), 74'd2);
      end
      chk("t1_grant_id",  74'(grant_id),   74'd2);
      chk("t1_pkt_done",  74'(pkt_active), 74'd0);

      // All requesters pending with 1-beat packets: strict rotation and one idle gap.
      do_reset();
      cap.delete();
      push_beat(0, 64'd0, 8'h01, 1'b1);
      push_beat(0, 64'd0, 8'h01, 1'b1);
      for (int i = 1; i < NUM_REQ; i++) push_beat(i, 64'(i), 8'h01, 1'b1);
      drain(60);
      chk("t2_count", 74'(cap.size()), 74'd5);
      for (int k = 0; k < 5 && k < cap.size(); k++) begin
         chk("t2_order", 74'(cap[k].w[8 +: 64]), 74'(order[k]));
         if (k > 0) chk("t2_gap", 74'(cap[k].cyc - cap[k-1].cyc), 74'd2);
      end

      // Gen1 pacing: beats on alternate cycles.
      m_gen2_mode = 1'b0;
      cap.delete();
      push_pkt(3, 4);
      drain(60);
      chk("t3_count", 74'(cap.size()), 74'd4);
      for (int k = 1; k < cap.size(); k++) chk("t3_alternate", 74'(cap[k].cyc - cap[k-1].cyc), 74'd2);
      m_gen2_mode = 1'b1;

      // Requester 1 stalls for 5 cycles mid-packet while requester 0 waits.
      step();
      cap.delete();
      push_pkt(1, 4);
      n = 0;
      while (pq[1].size() > 2 && n < 50) begin step(); n++; end
      push_pkt(0, 1);
      hold[1] = 1;
      repeat (5) step();
      chk("t4_grant_held", 74'(grant_id), 74'd1);
      hold[1] = 0;
      drain(60);
      chk("t4_count", 74'(cap.size()), 74'd5);
      if (cap.size() >= 3) chk("t4_idle_words", 74'(cap[2].cyc - cap[1].cyc), 74'd6);

      // Oversize: 6-beat packet against MAX_BEATS=4; flag sticks, data untouched.
      cap.delete();
      push_pkt(0, 6);
      drain(60);
      chk("t5_count", 74'(cap.size()), 74'd6);
      if (cap.size() == 6) chk("t5_tlast", 74'(cap[5].w[72]), 74'd1);
      chk("t5_err_sticky", 74'(err_oversize), 74'd1);
      repeat (3) step();
      chk("t5_err_still", 74'(err_oversize), 74'd1);

      // Reset mid-packet, then link_enable gating of new grants.
      push_pkt(2, 4);
      n = 0;
      while (pq[2].size() > 2 && n < 50) begin step(); n++; end
      rst_wr = 1'b1;
      step();
      rst_wr = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
      step();
      chk("t6_txfifo_zero",  txfifo_st_data, 74'd0);
      chk("t6_outputs_zero", 74'({req_tready, grant_id, pkt_active, err_oversize}), 74'd0);
      link_enable = 1'b0;
      push_pkt(1, 1);
      repeat (4) begin
         step();
         chk("t6_no_grant", 74'(pkt_active), 74'd0);
      end
      link_enable = 1'b1;
      step();
      chk("t6_grant_active", 74'(pkt_active), 74'd1);
      chk("t6_grant_id",     74'(grant_id),   74'd1);
      drain(30);

      // Randomized traffic in both modes, packets short enough to stay legal.
      do_reset();
      for (int m = 0; m < 2; m++) begin
         m_gen2_mode = (m == 0);
         for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (pq[i].size() == 0 && $urandom_range(0, 3) == 0) push_pkt(i, $urandom_range(1, 4));
               hold[i] = ($urandom_range(0, 7) == 0);
            end
            link_enable = ($urandom_range(0, 9) != 0);
            step();
         end
         for (int i = 0; i < NUM_REQ; i++) hold[i] = 0;
         link_enable = 1'b1;
         drain(400);
      end
      chk("rand_no_oversize", 74'(err_oversize), 74'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/axi_st_d64_nordy_tx_sched.md
# axi_st_d64_nordy_tx_sched

Packet-granular scheduler that shares one 64-bit no-ready AXI-ST transmit link between NUM_REQ requesters. Requesters see a normal tvalid/tready handshake. The link side emits one 74-bit txfifo_st_data word every cycle, either a beat or an idle word, with no backpressure. The block sits between user AXI-ST sources and the logic-link TX FIFO, paces beats for Gen1/Gen2 rate, and flags oversize packets.

## Interface
- NUM_REQ, 4: requester count, legal 2..8.
- MAX_BEATS, 256: packet-length limit in beats before err_oversize sets, legal 2..4096.
- clk_wr  in  1: single clock.
- rst_wr  in  1: reset, synchronous, active-high.
- req_tkeep  in  NUM_REQ*8: per-requester tkeep, requester i at [8i +: 8].
- req_tdata  in  NUM_REQ*64: per-requester tdata, requester i at [64i +: 64].
- req_tlast  in  NUM_REQ: per-requester tlast.
- req_tvalid  in  NUM_REQ: per-requester tvalid.
- req_tready  out  NUM_REQ: per-requester tready, one-hot or zero.
- link_enable  in  1: new packets may be granted only while high.
- m_gen2_mode  in  1: 1 = beat slot every cycle; 0 = beat slot every second cycle.
- txfifo_st_data  out  74: bits [7:0] tkeep, [71:8] tdata, [72] tlast, [73] tvalid.
- grant_id  out  clog2(NUM_REQ): current or last granted requester.
- pkt_active  out  1: a packet is in flight.
- err_oversize  out  1: sticky flag, cleared only by rst_wr.

## Operation
- States:
  - IDLE: no grant held.
  - GRANT: grant registered, first beat pending.
  - PKT: mid-packet.
  - GRANT and PKT behave identically for beat acceptance; GRANT exists for debug visibility only.
- IDLE → GRANT when link_enable=1 and any req_tvalid=1.
  - Winner is the first requester with tvalid=1, searching upward (modulo NUM_REQ) from rr_ptr.
  - grant_id and pkt_active register at this transition.
- GRANT/PKT:
  - req_tready[grant_id] = slot. All other tready bits are 0.
  - A beat is accepted when tvalid & tready.
  - GRANT → PKT on the first accepted beat without tlast.
  - On an accepted beat with tlast, from either state: → IDLE, rr_ptr ← grant_id+1 mod NUM_REQ, pkt_active ← 0.
- Slot generation:
  - m_gen2_mode=1: slot=1 and phase is held at 0.
  - m_gen2_mode=0: phase toggles every cycle and slot = (phase==0).
  - A mode change takes effect on the next cycle, including mid-packet.
- Granted requester drops tvalid mid-packet: the grant is held and idle words are emitted. There is no timeout.
- link_enable deasserted mid-packet: the packet completes. The signal gates only the IDLE → GRANT transition.
- Beat counter:
  - Increments per accepted beat and clears on tlast.
  - When an accepted beat without tlast brings the count to MAX_BEATS, err_oversize sets.
  - The counter saturates at MAX_BEATS.
  - Data still passes unchanged; no truncation or forced tlast.
- Output word:
  - Accepted beat: {1, tlast, tdata, tkeep}.
  - Otherwise: all zeros.
- Reset values: txfifo_st_data=0, req_tready=0, grant_id=0, pkt_active=0, err_oversize=0, rr_ptr=0, phase=0, state=IDLE, beat count=0.

## Timing
- Arbitration: 1 cycle. With tvalid first high at cycle N in IDLE, grant and tready are visible at N+1, given a slot.
- Output register: a beat accepted at cycle M appears on txfifo_st_data at M+1.
- Minimum inter-packet gap: tlast accepted at M means the next packet's first beat is accepted no earlier than M+2, so one idle word appears between packets.
- Gen2 throughput: one beat per cycle within a packet.
- Gen1 throughput: one beat per two cycles.
- A synchronous rst_wr asserted mid-packet forces all reset values on the next edge. The partial packet is dropped without a tlast word.
- Simultaneous tvalid from all requesters: the winner follows rr_ptr strictly, so each requester is served within NUM_REQ packets.

## Structure
- Package axi_st_d64_nordy_pkg holds:
  - Widths: TKEEP_W=8, TDATA_W=64, ST_W=74.
  - Field offsets: TKEEP_LSB=0, TDATA_LSB=8, TLAST_BIT=72, TVALID_BIT=73.
  - State enum: IDLE, GRANT, PKT.
- Sub-module axi_st_d64_nordy_rr_arb: combinational rotate-priority pick. Inputs: request vector and rr_ptr. Outputs: winner index and any-request.

## Test plan
- Single packet, Gen2: requester 2 sends 3 beats with tdata 0x11/0x22/0x33, tkeep 0xFF. Response: grant_id=2, three consecutive words with bit73=1, tlast only on the third, then pkt_active=0.
- All 4 requesters request continuously with 1-beat packets. Response: grant order 0,1,2,3,0, one idle word between packets.
- Gen1: 4-beat packet. Response: beats appear on alternate cycles and req_tready is 0 on odd phase.
- Requester 1 drops tvalid for 5 cycles mid-packet. Response: 5 idle words, grant_id stays 1, no other tready asserts.
- MAX_BEATS=4, packet of 6 beats. Response: err_oversize=1 after the 4th beat, all 6 beats are output, and the flag stays 1 after tlast.
- rst_wr asserted mid-packet, plus link_enable=0 with pending tvalid. Response: all outputs return to 0; no grant while link_enable=0, and a grant follows 1 cycle after re-enable.
